cu_vertex_cache_reuse_param_module: RTL
=======================================

Name: cu_vertex_cache_reuse_param_module

Overview:
- Parametrised successor to the PageRank PULL vertex-data reuse stage. It sits between the edge-data extract path and the read-command buffer.
- Intercepts vertex read commands and looks them up in a direct-mapped vertex cache of NUM_SETS entries.
- Hits are answered locally with no memory command issued. Misses are forwarded, and their responses fill the cache.
- Adds what the fixed block lacks: configurable depth and width, a per-tag outstanding-miss table, bypass mode, a drain-then-flush FSM, and hit/miss counters.

Parameters:
ADDR_WIDTH, 32, vertex word address width
DATA_WIDTH, 32, vertex data width per entry
NUM_SETS, 16, cache entries (power of 2, >=2); IDX_W = log2(NUM_SETS)
TAG_WIDTH, 5, command tag width; outstanding table depth = 2**TAG_WIDTH
CNT_WIDTH, 32, statistics counter width

Ports:
clock  in  1  sole clock
rst_in  in  1  synchronous, active-high reset
enabled_in  in  1  block enable; when 0, cmd_in_ready=0
bypass_in  in  1  1 = every command treated as miss, no lookups, no fills
flush_in  in  1  one-cycle request to invalidate all entries
flush_done_out  out  1  one-cycle pulse when flush completes
cmd_in_valid  in  1  read command valid
cmd_in_ready  out  1  command accepted when valid&ready
cmd_in_addr  in  ADDR_WIDTH  vertex address
cmd_in_tag  in  TAG_WIDTH  command tag
cmd_out_valid  out  1  forwarded miss command
cmd_out_ready  in  1  downstream accept
cmd_out_addr  out  ADDR_WIDTH  forwarded address
cmd_out_tag  out  TAG_WIDTH  forwarded tag
rsp_in_valid  in  1  memory response with data
rsp_in_tag  in  TAG_WIDTH  response tag
rsp_in_data  in  DATA_WIDTH  response data
rsp_out_valid  out  1  response to CU (no backpressure)
rsp_out_tag  out  TAG_WIDTH  tag
rsp_out_data  out  DATA_WIDTH  data
rsp_out_hit  out  1  1 = served from cache
hit_count_out  out  CNT_WIDTH  saturating hit counter
miss_count_out  out  CNT_WIDTH  saturating miss counter
error_out  out  1  sticky: response for non-pending tag

Behaviour:
- Reset (rst_in=1 at clock edge):
  - Every output is 0, including counters and error_out.
  - All valid bits are cleared, the pending table is cleared, the skid is empty, and the FSM is in IDLE.
  - Reset mid-operation discards in-flight misses and produces no output on the following cycle.
- Address split: index = addr[IDX_W-1:0], stored tag = addr[ADDR_WIDTH-1:IDX_W].
- cmd_in_ready is asserted only when all of the following hold:
  - enabled_in=1 and FSM=IDLE;
  - the forward register is empty, or cmd_out_ready=1 this cycle;
  - the hit skid is empty;
  - pending[cmd_in_tag]=0.
- Lookup on accept at cycle N (combinational lookup, registered result):
  - Hit (valid & tag match & bypass_in=0): rsp_out_valid=1 at N+1 with hit=1 and the cached data. hit_count +1.
  - Miss: cmd_out_valid=1 at N+1, held with stable addr/tag until cmd_out_ready. pending[tag] is set with the addr recorded. miss_count +1.
- Response: rsp_in_valid with pending[tag]=1 gives rsp_out_valid at M+1 with hit=0.
  - Clear pending[tag].
  - If bypass_in=0, write the data and stored tag to index(addr) and set valid. This overwrites any resident line (no LRU).
- Response with pending[tag]=0: dropped, error_out set (sticky until reset).
- Output collision (a hit result and a fill response in the same cycle):
  - The fill goes out first.
  - The hit is held in a 1-entry skid and goes out the next cycle.
  - The full skid forces cmd_in_ready=0.
- Same-cycle lookup and fill to the same index: the lookup sees the pre-fill contents.
- Counters saturate at all-ones.
- Flush FSM:
  - IDLE → DRAIN on flush_in.
  - DRAIN: cmd_in_ready=0. Wait until the pending table and the forward register are empty.
  - CLEAR: one cycle, all valid bits cleared.
  - DONE: flush_done_out=1 for one cycle, then → IDLE.
  - flush_in while not in IDLE is ignored.
  - Responses continue to fill during DRAIN.
- enabled_in=0: no new accepts. Outstanding responses are still processed.

Test Plan:
- Miss then hit (SETS=16): cmd 0x13 tag3 → cmd_out 0x13/3 at N+1; rsp_in tag3 data 0xDEADBEEF → rsp_out hit=0 next cycle. Then cmd 0x13 tag4 → rsp_out 0xDEADBEEF tag4 hit=1 at N+1, no cmd_out; hit=1, miss=1.
- Conflict eviction: fill 0x13, then 0x23 (index 3) misses and fills, then 0x13 misses again → miss_count=3.
- Collision: a hit and rsp_in tag7 in the same cycle → fill out at M+1, hit at M+2, cmd_in_ready=0 for one cycle.
- Flush with 2 misses outstanding → stays in DRAIN until both responses arrive; flush_done_out pulses 2 cycles after the last response; a subsequent cmd 0x13 misses.
- Bypass/back-pressure/errors: bypass_in=1 with a resident 0x13 → cmd_out issued, no fill; cmd_out_ready=0 for 5 cycles → cmd_out stable and cmd_in_ready=0; rsp_in tag9 not pending → error_out=1, no rsp_out.
- Reset mid-op: rst_in asserted with 3 pending misses → next cycle all outputs 0; a post-reset response tag → error_out=1.

Source files
------------

// File: rtl/cu_vertex_cache_reuse_param_module.sv
`default_nettype none
// ============================================================================
// Module   : cu_vertex_cache_reuse_param_module
// Purpose  : Direct-mapped vertex-data reuse cache placed between the
//            edge-data extract path and the read-command buffer. Hits are
//            answered locally. Misses are forwarded downstream, and their
//            responses fill the cache. Also provides a per-tag
//            outstanding-miss table, bypass mode, drain-then-flush sequencing
//            and saturating hit/miss counters.
// Ports    : clock/rst_in            - clock, synchronous active-high reset
//            enabled_in/bypass_in    - accept enable, force-miss mode
//            flush_in/flush_done_out - flush request / completion pulse
//            cmd_in_*                - incoming vertex read commands
//            cmd_out_*               - forwarded miss commands (held until ready)
//            rsp_in_*                - memory responses for forwarded misses
//            rsp_out_*               - responses to the CU (hit flag marks cache)
//            hit/miss_count_out      - saturating statistics
//            error_out               - sticky, response for a non-pending tag
// Revision : 1.0 - initial release
// ============================================================================
module cu_vertex_cache_reuse_param_module #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SETS   = 16,
    parameter int TAG_WIDTH  = 5,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  rst_in,
    input  logic                  enabled_in,
    input  logic                  bypass_in,
    input  logic                  flush_in,
    output logic                  flush_done_out,
    input  logic                  cmd_in_valid,
    output logic                  cmd_in_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_in_addr,
    input  logic [TAG_WIDTH-1:0]  cmd_in_tag,
    output logic                  cmd_out_valid,
    input  logic                  cmd_out_ready,
    output logic [ADDR_WIDTH-1:0] cmd_out_addr,
    output logic [TAG_WIDTH-1:0]  cmd_out_tag,
    input  logic                  rsp_in_valid,
    input  logic [TAG_WIDTH-1:0]  rsp_in_tag,
    input  logic [DATA_WIDTH-1:0] rsp_in_data,
    output logic                  rsp_out_valid,
    output logic [TAG_WIDTH-1:0]  rsp_out_tag,
    output logic [DATA_WIDTH-1:0] rsp_out_data,
    output logic                  rsp_out_hit,
    output logic [CNT_WIDTH-1:0]  hit_count_out,
    output logic [CNT_WIDTH-1:0]  miss_count_out,
    output logic                  error_out
);

    localparam int c_IDX_W  = $clog2(NUM_SETS);
    localparam int c_STAG_W = ADDR_WIDTH - c_IDX_W;
    localparam int c_DEPTH  = 2 ** TAG_WIDTH;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_DRAIN = 2'd1;
    localparam logic [1:0] c_ST_CLEAR = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    // Cache storage
    logic [NUM_SETS-1:0]   r_valid;
    logic [c_STAG_W-1:0]   r_stag_mem [NUM_SETS];
    logic [DATA_WIDTH-1:0] r_data_mem [NUM_SETS];

    // Outstanding-miss table, indexed by command tag
    logic [c_DEPTH-1:0]    r_pending;
    logic [ADDR_WIDTH-1:0] r_pend_addr [c_DEPTH];

    // Forward register, hit skid, response output register
    logic                  r_fwd_valid;
    logic [ADDR_WIDTH-1:0] r_fwd_addr;
    logic [TAG_WIDTH-1:0]  r_fwd_tag;
    logic                  r_skid_valid;
    logic [TAG_WIDTH-1:0]  r_skid_tag;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic                  r_rsp_valid;
    logic [TAG_WIDTH-1:0]  r_rsp_tag;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_hit;
    logic [CNT_WIDTH-1:0]  r_hit_cnt;
    logic [CNT_WIDTH-1:0]  r_miss_cnt;
    logic                  r_error;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic                  w_idle;
    logic                  w_clear;
    logic                  w_done;

    logic [c_IDX_W-1:0]    w_lkp_idx;
    logic [c_STAG_W-1:0]   w_lkp_stag;
    logic                  w_lkp_hit;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_acc_hit;
    logic                  w_acc_miss;
    logic                  w_rsp_ok;
    logic                  w_rsp_bad;
    logic [ADDR_WIDTH-1:0] w_fill_addr;
    logic [c_IDX_W-1:0]    w_fill_idx;
    logic                  w_fill_en;
    logic [c_DEPTH-1:0]    w_pending_next;
    logic                  w_fwd_valid_next;
    logic                  w_drained;

    // Lookup reads the arrays before this cycle's fill lands, so a same-index
    // lookup and fill in one cycle sees the old contents.
    assign w_lkp_idx  = cmd_in_addr[c_IDX_W-1:0];
    assign w_lkp_stag = cmd_in_addr[ADDR_WIDTH-1:c_IDX_W];
    assign w_lkp_hit  = !bypass_in && r_valid[w_lkp_idx] && (r_stag_mem[w_lkp_idx] == w_lkp_stag);

    // Held low during reset so every output reads zero while rst_in is high.
    assign w_ready = !rst_in && enabled_in && w_idle && (!r_fwd_valid || cmd_out_ready)
                     && !r_skid_valid && !r_pending[cmd_in_tag];
    assign w_accept   = cmd_in_valid && w_ready;
    assign w_acc_hit  = w_accept && w_lkp_hit;
    assign w_acc_miss = w_accept && !w_lkp_hit;

    assign w_rsp_ok    = rsp_in_valid && r_pending[rsp_in_tag];
    assign w_rsp_bad   = rsp_in_valid && !r_pending[rsp_in_tag];
    assign w_fill_addr = r_pend_addr[rsp_in_tag];
    assign w_fill_idx  = w_fill_addr[c_IDX_W-1:0];
    assign w_fill_en   = w_rsp_ok && !bypass_in;

    always_comb begin
        w_pending_next = r_pending;
        if (w_rsp_ok)   w_pending_next[rsp_in_tag] = 1'b0;
        if (w_acc_miss) w_pending_next[cmd_in_tag] = 1'b1;
    end

    assign w_fwd_valid_next = w_acc_miss || (r_fwd_valid && !cmd_out_ready);
    // Drain completes on the cycle the last response or forward hand-off
    // happens, so CLEAR follows immediately.
    assign w_drained = (w_pending_next == '0) && !w_fwd_valid_next;

    // FSM: state register
    always_ff @(posedge clock) begin
        if (rst_in) r_state <= c_ST_IDLE;
        else        r_state <= w_state_next;
    end

    // FSM: next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (flush_in)  w_state_next = c_ST_DRAIN;
            c_ST_DRAIN: if (w_drained) w_state_next = c_ST_CLEAR;
            c_ST_CLEAR: w_state_next = c_ST_DONE;
            c_ST_DONE:  w_state_next = c_ST_IDLE;
            default:    w_state_next = c_ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_idle  = (r_state == c_ST_IDLE);
        w_clear = (r_state == c_ST_CLEAR);
        w_done  = (r_state == c_ST_DONE);
    end

    // Array contents carry no reset; validity is tracked by r_valid/r_pending.
    always_ff @(posedge clock) begin
        if (!rst_in && w_fill_en) begin
            r_stag_mem[w_fill_idx] <= w_fill_addr[ADDR_WIDTH-1:c_IDX_W];
            r_data_mem[w_fill_idx] <= rsp_in_data;
        end
        if (!rst_in && w_acc_miss) r_pend_addr[cmd_in_tag] <= cmd_in_addr;
    end

    always_ff @(posedge clock) begin
        if (rst_in) begin
            r_valid      <= '0;
            r_pending    <= '0;
            r_fwd_valid  <= 1'b0;
            r_fwd_addr   <= '0;
            r_fwd_tag    <= '0;
            r_skid_valid <= 1'b0;
            r_skid_tag   <= '0;
            r_skid_data  <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_tag    <= '0;
            r_rsp_data   <= '0;
            r_rsp_hit    <= 1'b0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
            r_error      <= 1'b0;
        end else begin
            r_pending <= w_pending_next;

            if (w_clear)        r_valid             <= '0;
            else if (w_fill_en) r_valid[w_fill_idx] <= 1'b1;

            if (w_acc_miss) begin
                r_fwd_valid <= 1'b1;
                r_fwd_addr  <= cmd_in_addr;
                r_fwd_tag   <= cmd_in_tag;
            end else if (cmd_out_ready) begin
                r_fwd_valid <= 1'b0;
            end

            // Fill responses win the output port; a colliding hit parks in the
            // skid and is emitted once no fill competes for the port.
            if (w_rsp_ok) begin
                r_rsp_valid <= 1'b1;
                r_rsp_tag   <= rsp_in_tag;
                r_rsp_data  <= rsp_in_data;
                r_rsp_hit   <= 1'b0;
                if (w_acc_hit) begin
                    r_skid_valid <= 1'b1;
                    r_skid_tag   <= cmd_in_tag;
                    r_skid_data  <= r_data_mem[w_lkp_idx];
                end
            end else if (r_skid_valid) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_tag    <= r_skid_tag;
                r_rsp_data   <= r_skid_data;
                r_rsp_hit    <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_acc_hit) begin
                r_rsp_valid <= 1'b1;
                r_rsp_tag   <= cmd_in_tag;
                r_rsp_data  <= r_data_mem[w_lkp_idx];
                r_rsp_hit   <= 1'b1;
            end else begin
                r_rsp_valid <= 1'b0;
            end

            if (w_acc_hit && (r_hit_cnt != c_CNT_MAX))   r_hit_cnt  <= r_hit_cnt + c_CNT_ONE;
            if (w_acc_miss && (r_miss_cnt != c_CNT_MAX)) r_miss_cnt <= r_miss_cnt + c_CNT_ONE;
            if (w_rsp_bad) r_error <= 1'b1;
        end
    end

    assign cmd_in_ready   = w_ready;
    assign flush_done_out = w_done;
    assign cmd_out_valid  = r_fwd_valid;
    assign cmd_out_addr   = r_fwd_addr;
    assign cmd_out_tag    = r_fwd_tag;
    assign rsp_out_valid  = r_rsp_valid;
    assign rsp_out_tag    = r_rsp_tag;
    assign rsp_out_data   = r_rsp_data;
    assign rsp_out_hit    = r_rsp_hit;
    assign hit_count_out  = r_hit_cnt;
    assign miss_count_out = r_miss_cnt;
    assign error_out      = r_error;

endmodule
`default_nettype wire
